// File: rtl/core_msg_bcast_tx_if.sv
// Broadcast-message bundle: the core's write-message inputs and the
// valid/ready broadcast output toward the inter-core network.
interface core_msg_bcast_tx_if #(
    parameter int DMEM_ADDR_WIDTH = 15,
    parameter int CORE_ID_WIDTH   = 4
);
    logic [31:0]                core_msg_data;
    logic [DMEM_ADDR_WIDTH-1:0] core_msg_addr;
    logic [3:0]                 core_msg_strb;
    logic                       core_msg_valid;

    logic [31:0]                bc_msg_data;
    logic [DMEM_ADDR_WIDTH-1:0] bc_msg_addr;
    logic [3:0]                 bc_msg_strb;
    logic [CORE_ID_WIDTH-1:0]   bc_msg_core_id;
    logic                       bc_msg_valid;
    logic                       bc_msg_ready;

    // Transmitter view: takes core messages, drives the broadcast side.
    modport master (
        input  core_msg_data, core_msg_addr, core_msg_strb, core_msg_valid,
        output bc_msg_data, bc_msg_addr, bc_msg_strb, bc_msg_core_id, bc_msg_valid,
        input  bc_msg_ready
    );

    // Surrounding view: core message source plus the broadcast consumer.
    modport slave (
        output core_msg_data, core_msg_addr, core_msg_strb, core_msg_valid,
        input  bc_msg_data, bc_msg_addr, bc_msg_strb, bc_msg_core_id, bc_msg_valid,
        output bc_msg_ready
    );
endinterface

// File: rtl/core_msg_bcast_tx.sv
// Transmit end of the per-core broadcast-message path. Core write messages
// (no backpressure toward the core) are buffered in a FIFO and presented to
// the broadcast network through a registered output stage. Messages that
// find the FIFO full are dropped, counted and flagged.
module core_msg_bcast_tx #(
    parameter int DMEM_ADDR_WIDTH = 15,
    parameter int CORE_ID_WIDTH   = 4,
    parameter int CORE_ID         = 0,
    parameter int FIFO_DEPTH      = 16,
    parameter int FIFO_ADDR_WIDTH = $clog2(FIFO_DEPTH),
    parameter int DROP_CNT_WIDTH  = 16
) (
    input  logic                       clk,
    input  logic                       rst,
    core_msg_bcast_tx_if.master        bus,
    input  logic                       clear_err,
    output logic                       overflow,
    output logic [DROP_CNT_WIDTH-1:0]  drop_count,
    output logic [FIFO_ADDR_WIDTH:0]   fifo_level
);
    localparam int PTR_W   = FIFO_ADDR_WIDTH + 1;
    localparam int ENTRY_W = 32 + DMEM_ADDR_WIDTH + 4;

    typedef enum logic {OUT_EMPTY = 1'b0, OUT_FULL = 1'b1} out_state_t;

    out_state_t           state_q, state_d;
    logic [PTR_W-1:0]     wr_ptr, rd_ptr;
    logic [ENTRY_W-1:0]   mem [FIFO_DEPTH];
    logic [ENTRY_W-1:0]   head;
    logic                 empty, full, msg_in, push, drop, pop;
    logic [PTR_W-1:0]     count;

    // Saturating increment for the drop counter.
    function automatic logic [DROP_CNT_WIDTH-1:0] sat_inc(input logic [DROP_CNT_WIDTH-1:0] v);
        return (&v) ? v : v + DROP_CNT_WIDTH'(1);
    endfunction

    // Extra pointer MSB separates full from empty when the low bits match.
    assign empty  = (wr_ptr == rd_ptr);
    assign full   = (wr_ptr[FIFO_ADDR_WIDTH] != rd_ptr[FIFO_ADDR_WIDTH]) &&
                    (wr_ptr[FIFO_ADDR_WIDTH-1:0] == rd_ptr[FIFO_ADDR_WIDTH-1:0]);
    assign count  = wr_ptr - rd_ptr;

    // Byte-enable-free writes carry nothing and are ignored outright.
    assign msg_in = bus.core_msg_valid && (bus.core_msg_strb != 4'h0);
    // Full is taken from registered state, so a same-cycle pop cannot save a write.
    assign push   = msg_in && !full;
    assign drop   = msg_in && full;

    assign head   = mem[rd_ptr[FIFO_ADDR_WIDTH-1:0]];

    assign fifo_level         = count + {{FIFO_ADDR_WIDTH{1'b0}}, (state_q == OUT_FULL)};
    assign bus.bc_msg_valid   = (state_q == OUT_FULL);
    assign bus.bc_msg_core_id = CORE_ID_WIDTH'(CORE_ID);

    // FIFO storage write; contents need no reset since the pointers gate them.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr[FIFO_ADDR_WIDTH-1:0]] <= {bus.core_msg_strb, bus.core_msg_addr, bus.core_msg_data};
        end
    end

    // Read/write pointers.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
        end
    end

    // Output-stage state register.
    always_ff @(posedge clk) begin
        if (rst) state_q <= OUT_EMPTY;
        else     state_q <= state_d;
    end

    // Output-stage next state and FIFO pop: refill whenever the register is
    // empty or is being handed off this cycle.
    always_comb begin
        state_d = state_q;
        pop     = 1'b0;
        case (state_q)
            OUT_EMPTY: begin
                if (!empty) begin
                    pop     = 1'b1;
                    state_d = OUT_FULL;
                end
            end
            OUT_FULL: begin
                if (bus.bc_msg_ready) begin
                    if (!empty) pop = 1'b1;
                    else        state_d = OUT_EMPTY;
                end
            end
            default: state_d = OUT_EMPTY;
        endcase
    end

    // Output register; only a pop changes it, so fields hold while stalled.
    always_ff @(posedge clk) begin
        if (rst) begin
            bus.bc_msg_data <= '0;
            bus.bc_msg_addr <= '0;
            bus.bc_msg_strb <= '0;
        end else if (pop) begin
            {bus.bc_msg_strb, bus.bc_msg_addr, bus.bc_msg_data} <= head;
        end
    end

    // Loss tracking; a drop in the same cycle as clear_err restarts at one.
    always_ff @(posedge clk) begin
        if (rst) begin
            overflow   <= 1'b0;
            drop_count <= '0;
        end else if (drop) begin
            overflow   <= 1'b1;
            drop_count <= clear_err ? DROP_CNT_WIDTH'(1) : sat_inc(drop_count);
        end else if (clear_err) begin
            overflow   <= 1'b0;
            drop_count <= '0;
        end
    end
endmodule

// File: tb/tb_core_msg_bcast_tx.sv
// Directed bench for core_msg_bcast_tx with FIFO_DEPTH=16 and CORE_ID=5.
module tb_core_msg_bcast_tx;
    localparam int AW    = 15;
    localparam int IDW   = 4;
    localparam int DEPTH = 16;
    localparam int FAW   = $clog2(DEPTH);
    localparam int DCW   = 16;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic           clear_err = 1'b0;
    logic           overflow;
    logic [DCW-1:0] drop_count;
    logic [FAW:0]   fifo_level;

    int chk_cnt  = 0;
    int pass_cnt = 0;

    core_msg_bcast_tx_if #(.DMEM_ADDR_WIDTH(AW), .CORE_ID_WIDTH(IDW)) bus ();

    core_msg_bcast_tx #(
        .DMEM_ADDR_WIDTH(AW), .CORE_ID_WIDTH(IDW), .CORE_ID(5),
        .FIFO_DEPTH(DEPTH), .DROP_CNT_WIDTH(DCW)
    ) dut (
        .clk(clk), .rst(rst), .bus(bus), .clear_err(clear_err),
        .overflow(overflow), .drop_count(drop_count), .fifo_level(fifo_level)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [31:0] d, input logic [AW-1:0] a, input logic [3:0] s);
        bus.core_msg_data  = d;
        bus.core_msg_addr  = a;
        bus.core_msg_strb  = s;
        bus.core_msg_valid = 1'b1;
        step();
        bus.core_msg_valid = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
        chk_cnt++; if (bus.bc_msg_valid !== 1'b0) $display("FAIL reset_valid got %b want 0", bus.bc_msg_valid); else pass_cnt++;
        chk_cnt++; if (fifo_level !== 5'd0) $display("FAIL reset_level got %0d want 0", fifo_level); else pass_cnt++;
        chk_cnt++; if ({overflow, drop_count} !== 17'd0) $display("FAIL reset_err got ovf=%b cnt=%0d want 0/0", overflow, drop_count); else pass_cnt++;
        chk_cnt++; if ({bus.bc_msg_data, bus.bc_msg_addr, bus.bc_msg_strb} !== '0) $display("FAIL reset_fields got %h/%h/%h want 0", bus.bc_msg_data, bus.bc_msg_addr, bus.bc_msg_strb); else pass_cnt++;
    endtask

    task automatic test_single();
        bus.bc_msg_ready = 1'b1;
        push(32'hDEADBEEF, 15'h7000, 4'hF);
        chk_cnt++; if (bus.bc_msg_valid !== 1'b0) $display("FAIL single_early_valid got %b want 0", bus.bc_msg_valid); else pass_cnt++;
        chk_cnt++; if (fifo_level !== 5'd1) $display("FAIL single_level_stored got %0d want 1", fifo_level); else pass_cnt++;
        step();
        chk_cnt++; if (bus.bc_msg_valid !== 1'b1) $display("FAIL single_valid got %b want 1", bus.bc_msg_valid); else pass_cnt++;
        chk_cnt++; if ({bus.bc_msg_data, bus.bc_msg_addr, bus.bc_msg_strb} !== {32'hDEADBEEF, 15'h7000, 4'hF})
            $display("FAIL single_fields got %h/%h/%h want deadbeef/7000/f", bus.bc_msg_data, bus.bc_msg_addr, bus.bc_msg_strb); else pass_cnt++;
        chk_cnt++; if (bus.bc_msg_core_id !== 4'd5) $display("FAIL single_core_id got %0d want 5", bus.bc_msg_core_id); else pass_cnt++;
        step();
        chk_cnt++; if (bus.bc_msg_valid !== 1'b0) $display("FAIL single_after_valid got %b want 0", bus.bc_msg_valid); else pass_cnt++;
        chk_cnt++; if (fifo_level !== 5'd0) $display("FAIL single_after_level got %0d want 0", fifo_level); else pass_cnt++;
    endtask

    task automatic test_backpressure();
        bus.bc_msg_ready = 1'b0;
        for (int i = 0; i < 5; i++) push(32'h100 + i, AW'(i * 4), 4'hF);
        chk_cnt++; if (fifo_level !== 5'd5) $display("FAIL bp_level got %0d want 5", fifo_level); else pass_cnt++;
        for (int k = 0; k < 3; k++) begin
            chk_cnt++; if ({bus.bc_msg_valid, bus.bc_msg_data, bus.bc_msg_addr} !== {1'b1, 32'h100, 15'h0})
                $display("FAIL bp_hold%0d got v=%b d=%h a=%h want 1/100/0", k, bus.bc_msg_valid, bus.bc_msg_data, bus.bc_msg_addr); else pass_cnt++;
            step();
        end
        bus.bc_msg_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            chk_cnt++; if ({bus.bc_msg_valid, bus.bc_msg_data, bus.bc_msg_addr} !== {1'b1, 32'h100 + i, AW'(i * 4)})
                $display("FAIL bp_drain%0d got v=%b d=%h a=%h want 1/%h/%h", i, bus.bc_msg_valid, bus.bc_msg_data, bus.bc_msg_addr, 32'h100 + i, i * 4); else pass_cnt++;
            step();
        end
        chk_cnt++; if ({bus.bc_msg_valid, fifo_level} !== 6'd0) $display("FAIL bp_empty got v=%b lvl=%0d want 0/0", bus.bc_msg_valid, fifo_level); else pass_cnt++;
    endtask

    task automatic test_overflow();
        bus.bc_msg_ready = 1'b0;
        for (int i = 0; i < 20; i++) push(32'h2000 + i, AW'(i), 4'hF);
        chk_cnt++; if (fifo_level !== 5'd17) $display("FAIL ovf_level got %0d want 17", fifo_level); else pass_cnt++;
        chk_cnt++; if (overflow !== 1'b1) $display("FAIL ovf_flag got %b want 1", overflow); else pass_cnt++;
        chk_cnt++; if (drop_count !== 16'd3) $display("FAIL ovf_count got %0d want 3", drop_count); else pass_cnt++;
        bus.bc_msg_ready = 1'b1;
        for (int i = 0; i < 17; i++) begin
            chk_cnt++; if ({bus.bc_msg_valid, bus.bc_msg_data} !== {1'b1, 32'h2000 + i})
                $display("FAIL ovf_drain%0d got v=%b d=%h want 1/%h", i, bus.bc_msg_valid, bus.bc_msg_data, 32'h2000 + i); else pass_cnt++;
            step();
        end
        chk_cnt++; if (bus.bc_msg_valid !== 1'b0) $display("FAIL ovf_extra got valid=%b d=%h want 0", bus.bc_msg_valid, bus.bc_msg_data); else pass_cnt++;
        clear_err = 1'b1;
        step();
        clear_err = 1'b0;
        chk_cnt++; if ({overflow, drop_count} !== 17'd0) $display("FAIL clear_alone got ovf=%b cnt=%0d want 0/0", overflow, drop_count); else pass_cnt++;
    endtask

    task automatic test_strb_filter();
        bus.bc_msg_ready = 1'b0;
        for (int i = 0; i < 8; i++) push(32'h3000 + i, AW'(i), (i % 2 == 1) ? 4'h3 : 4'h0);
        chk_cnt++; if (fifo_level !== 5'd4) $display("FAIL strb_level got %0d want 4", fifo_level); else pass_cnt++;
        chk_cnt++; if ({overflow, drop_count} !== 17'd0) $display("FAIL strb_drops got ovf=%b cnt=%0d want 0/0", overflow, drop_count); else pass_cnt++;
        bus.bc_msg_ready = 1'b1;
        for (int j = 0; j < 4; j++) begin
            chk_cnt++; if ({bus.bc_msg_valid, bus.bc_msg_data, bus.bc_msg_strb} !== {1'b1, 32'h3001 + 2 * j, 4'h3})
                $display("FAIL strb_out%0d got v=%b d=%h s=%h want 1/%h/3", j, bus.bc_msg_valid, bus.bc_msg_data, bus.bc_msg_strb, 32'h3001 + 2 * j); else pass_cnt++;
            step();
        end
        chk_cnt++; if (bus.bc_msg_valid !== 1'b0) $display("FAIL strb_extra got valid=%b want 0", bus.bc_msg_valid); else pass_cnt++;
    endtask

    task automatic test_clear_collision();
        bus.bc_msg_ready = 1'b0;
        for (int i = 0; i < 17; i++) push(32'h4000 + i, AW'(i), 4'hF);
        chk_cnt++; if ({fifo_level, overflow} !== {5'd17, 1'b0}) $display("FAIL coll_fill got lvl=%0d ovf=%b want 17/0", fifo_level, overflow); else pass_cnt++;
        clear_err = 1'b1;
        push(32'h4F00, 15'h0, 4'hF);
        clear_err = 1'b0;
        chk_cnt++; if ({overflow, drop_count} !== {1'b1, 16'd1}) $display("FAIL coll_drop_wins got ovf=%b cnt=%0d want 1/1", overflow, drop_count); else pass_cnt++;
        clear_err = 1'b1;
        step();
        clear_err = 1'b0;
        chk_cnt++; if ({overflow, drop_count} !== 17'd0) $display("FAIL coll_clear got ovf=%b cnt=%0d want 0/0", overflow, drop_count); else pass_cnt++;
        // Write while full with a simultaneous pop is still dropped.
        bus.bc_msg_ready = 1'b1;
        push(32'h4F01, 15'h1, 4'hF);
        chk_cnt++; if ({fifo_level, drop_count} !== {5'd16, 16'd1}) $display("FAIL full_pop_drop got lvl=%0d cnt=%0d want 16/1", fifo_level, drop_count); else pass_cnt++;
        chk_cnt++; if (bus.bc_msg_data !== 32'h4001) $display("FAIL full_pop_head got %h want 4001", bus.bc_msg_data); else pass_cnt++;
        for (int i = 0; i < 16; i++) step();
        chk_cnt++; if ({bus.bc_msg_valid, fifo_level} !== 6'd0) $display("FAIL coll_drain got v=%b lvl=%0d want 0/0", bus.bc_msg_valid, fifo_level); else pass_cnt++;
    endtask

    task automatic test_reset_midstream();
        bus.bc_msg_ready = 1'b0;
        for (int i = 0; i < 6; i++) push(32'h5000 + i, AW'(i), 4'hF);
        chk_cnt++; if (fifo_level !== 5'd6) $display("FAIL mid_level got %0d want 6", fifo_level); else pass_cnt++;
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk_cnt++; if ({bus.bc_msg_valid, fifo_level, drop_count, overflow} !== '0)
            $display("FAIL mid_reset got v=%b lvl=%0d cnt=%0d ovf=%b want 0", bus.bc_msg_valid, fifo_level, drop_count, overflow); else pass_cnt++;
        bus.bc_msg_ready = 1'b1;
        push(32'hCAFEF00D, 15'h0124, 4'h5);
        step();
        chk_cnt++; if ({bus.bc_msg_valid, bus.bc_msg_data, bus.bc_msg_addr, bus.bc_msg_strb} !== {1'b1, 32'hCAFEF00D, 15'h0124, 4'h5})
            $display("FAIL mid_after got v=%b %h/%h/%h want 1 cafef00d/0124/5", bus.bc_msg_valid, bus.bc_msg_data, bus.bc_msg_addr, bus.bc_msg_strb); else pass_cnt++;
        step();
        chk_cnt++; if ({bus.bc_msg_valid, fifo_level} !== 6'd0) $display("FAIL mid_final got v=%b lvl=%0d want 0/0", bus.bc_msg_valid, fifo_level); else pass_cnt++;
    endtask

    initial begin
        bus.core_msg_data  = '0;
        bus.core_msg_addr  = '0;
        bus.core_msg_strb  = '0;
        bus.core_msg_valid = 1'b0;
        bus.bc_msg_ready   = 1'b0;
        test_reset();
        test_single();
        test_backpressure();
        test_overflow();
        test_strb_filter();
        test_clear_collision();
        test_reset_midstream();
        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end
endmodule
